// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, the hard-wired zero register index and the
//               forwarding-source encoding for the LEGv8 pipeline.
// Contents    : DATA_W, ADDR_W, ZERO_REG, ZERO_IDX, fwd_sel_t
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W   = 64;  // operand/result width
  localparam int ADDR_W   = 5;   // register index width
  localparam int ZERO_REG = 31;  // hard-wired zero register index

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  // Where an operand value was taken from.
  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand forwarding selector for one source register.
//               Priority: zero register > EX/MEM > MEM/WB > register file.
// Ports       : src                         - source register index
//               exm_valid/exm_reg_write/... - EX/MEM qualifiers, rd, result
//               wb_valid/wb_reg_write/...   - MEM/WB qualifiers, rd, data
//               rf_data                     - register file read data
//               value                       - selected operand value
//               sel                         - which source was selected
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic              exm_valid,
  input  logic              exm_reg_write,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] value,
  output fwd_sel_t          sel
);

  always_comb begin
    sel   = FWD_RF;
    value = rf_data;
    // X31 reads as zero even if an older instruction claims to write it.
    if (src == ZERO_IDX) begin
      sel   = FWD_ZERO;
      value = '0;
    end else if (exm_valid && exm_reg_write && (exm_rd == src)) begin
      sel   = FWD_EXM;
      value = exm_result;
    end else if (wb_valid && wb_reg_write && (wb_rd == src)) begin
      // The regfile write lands on the same edge, so its read port is stale.
      sel   = FWD_WB;
      value = wb_data;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : ID->EX boundary of the 64-bit LEGv8 pipeline. Drives the
//               regfile read addresses, forwards newer results from EX/MEM
//               and MEM/WB, detects load-use hazards and owns the ID/EX
//               pipeline register.
// Ports       : id_*            - decode slot
//               ReadRegister*/ReadData* - regfile read interface
//               exm_*, wb_*     - forwarding sources
//               flush, hold     - squash / global freeze
//               id_stall        - decode/fetch must not advance
//               ex_*            - registered ID/EX outputs
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rn,
  input  logic [ADDR_W-1:0] id_rm,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              exm_valid,
  input  logic              exm_reg_write,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read
);

  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  fwd_sel_t          rn_sel_unused;
  fwd_sel_t          rm_sel_unused;
  logic              load_use;

  logic              ex_valid_q,      ex_valid_d;
  logic [DATA_W-1:0] ex_a_q,          ex_a_d;
  logic [DATA_W-1:0] ex_b_q,          ex_b_d;
  logic [DATA_W-1:0] ex_store_data_q, ex_store_data_d;
  logic [ADDR_W-1:0] ex_rd_q,         ex_rd_d;
  logic              ex_reg_write_q,  ex_reg_write_d;
  logic              ex_mem_read_q,   ex_mem_read_d;

  assign ReadRegister1 = id_rn;
  assign ReadRegister2 = id_rm;

  fwd_mux u_fwd_rn (
    .src           (id_rn),
    .exm_valid     (exm_valid),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_data       (ReadData1),
    .value         (rn_val),
    .sel           (rn_sel_unused)
  );

  fwd_mux u_fwd_rm (
    .src           (id_rm),
    .exm_valid     (exm_valid),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_data       (ReadData2),
    .value         (rm_val),
    .sel           (rm_sel_unused)
  );

  // Load in EX whose result is needed now. rm is compared even when the
  // immediate replaces operand B, since stores still read rm as data.
  assign load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != ZERO_IDX) &&
                    id_valid && ((ex_rd_q == id_rn) || (ex_rd_q == id_rm));

  // A flush squashes the slot anyway, so it never needs to be re-presented.
  assign id_stall = !reset && (hold || (load_use && !flush));

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_a_d          = ex_a_q;
    ex_b_d          = ex_b_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    if (reset) begin
      ex_valid_d      = 1'b0;
      ex_a_d          = '0;
      ex_b_d          = '0;
      ex_store_data_d = '0;
      ex_rd_d         = '0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
    end else if (hold) begin
      // keep everything
    end else if (flush || load_use) begin
      // Bubble: only the qualifiers are cleared, datapath regs are don't-care.
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else begin
      ex_valid_d      = id_valid;
      ex_a_d          = rn_val;
      ex_b_d          = id_use_imm ? id_imm : rm_val;
      ex_store_data_d = rm_val;
      ex_rd_d         = id_rd;
      ex_reg_write_d  = id_valid & id_reg_write;
      ex_mem_read_d   = id_valid & id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    ex_valid_q      <= ex_valid_d;
    ex_a_q          <= ex_a_d;
    ex_b_q          <= ex_b_d;
    ex_store_data_q <= ex_store_data_d;
    ex_rd_q         <= ex_rd_d;
    ex_reg_write_q  <= ex_reg_write_d;
    ex_mem_read_q   <= ex_mem_read_d;
  end

  assign ex_valid      = ex_valid_q;
  assign ex_a          = ex_a_q;
  assign ex_b          = ex_b_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;

endmodule : operand_fetch_stage
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Scoreboard bench for operand_fetch_stage. Each stimulus cycle
//               queues its expected id_stall/read-address values and the
//               expected ID/EX contents after the edge; two monitor
//               processes pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;
  import cpu_pkg::*;

  localparam logic [6:0] M_V   = 7'h01;
  localparam logic [6:0] M_A   = 7'h02;
  localparam logic [6:0] M_B   = 7'h04;
  localparam logic [6:0] M_SD  = 7'h08;
  localparam logic [6:0] M_RD  = 7'h10;
  localparam logic [6:0] M_RW  = 7'h20;
  localparam logic [6:0] M_MR  = 7'h40;
  localparam logic [6:0] M_ALL = 7'h7F;

  typedef struct {
    string             nm;
    logic              stall;
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
  } comb_item_t;

  typedef struct {
    string             nm;
    logic [6:0]        m;
    logic              v;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sd;
    logic [ADDR_W-1:0] rd;
    logic              rw;
    logic              mr;
  } ex_item_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_reg_write, id_mem_read, id_use_imm;
  logic [ADDR_W-1:0] id_rn, id_rm, id_rd;
  logic [DATA_W-1:0] id_imm;
  logic [ADDR_W-1:0] ReadRegister1, ReadRegister2;
  logic [DATA_W-1:0] ReadData1, ReadData2;
  logic exm_valid, exm_reg_write, wb_valid, wb_reg_write;
  logic [ADDR_W-1:0] exm_rd, wb_rd;
  logic [DATA_W-1:0] exm_result, wb_data;
  logic flush, hold, id_stall;
  logic ex_valid, ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_a, ex_b, ex_store_data;
  logic [ADDR_W-1:0] ex_rd;

  comb_item_t cq[$];
  ex_item_t   eq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .exm_valid     (exm_valid),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .hold          (hold),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read)
  );

  task automatic chk(input string nm, input string fld,
                     input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=0x%0h expected=0x%0h", nm, fld, act, exp);
    end
  endtask

  // Combinational outputs, sampled mid-cycle while inputs are stable.
  initial begin
    forever begin
      comb_item_t c;
      @(negedge clk);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk(c.nm, "id_stall", {63'd0, id_stall}, {63'd0, c.stall});
        chk(c.nm, "ReadRegister1", {59'd0, ReadRegister1}, {59'd0, c.rr1});
        chk(c.nm, "ReadRegister2", {59'd0, ReadRegister2}, {59'd0, c.rr2});
      end
    end
  end

  // Registered outputs, sampled just after the capturing edge.
  initial begin
    forever begin
      ex_item_t e;
      @(posedge clk);
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        if (e.m[0]) chk(e.nm, "ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
        if (e.m[1]) chk(e.nm, "ex_a", ex_a, e.a);
        if (e.m[2]) chk(e.nm, "ex_b", ex_b, e.b);
        if (e.m[3]) chk(e.nm, "ex_store_data", ex_store_data, e.sd);
        if (e.m[4]) chk(e.nm, "ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
        if (e.m[5]) chk(e.nm, "ex_reg_write", {63'd0, ex_reg_write}, {63'd0, e.rw});
        if (e.m[6]) chk(e.nm, "ex_mem_read", {63'd0, ex_mem_read}, {63'd0, e.mr});
      end
    end
  end

  // Queue expectations for the inputs currently driven, then advance one cycle.
  task automatic cyc(input string nm, input logic st, input logic [6:0] m,
                     input logic v, input logic [DATA_W-1:0] a,
                     input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] sd,
                     input logic [ADDR_W-1:0] rd, input logic rw, input logic mr);
    comb_item_t c;
    ex_item_t   e;
    c.nm = nm; c.stall = st; c.rr1 = id_rn; c.rr2 = id_rm;
    e.nm = nm; e.m = m; e.v = v; e.a = a; e.b = b; e.sd = sd;
    e.rd = rd; e.rw = rw; e.mr = mr;
    cq.push_back(c);
    eq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fwd();
    exm_valid = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; id_valid = 1; id_rn = 3; id_rm = 0; id_rd = 1;
    id_reg_write = 1; id_mem_read = 0; id_imm = 0; id_use_imm = 0;
    ReadData1 = 64'h30; ReadData2 = 0; flush = 0; hold = 0;
    clear_fwd();
    @(posedge clk);
    #2;

    // Reset with a valid decode slot present
    cyc("reset1", 0, M_ALL, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset2", 0, M_ALL, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc("first", 0, M_V | M_A | M_RD | M_RW | M_MR, 1, 64'h30, 0, 0, 1, 1, 0);

    // Zero register never forwarded
    id_rn = 31; ReadData1 = 64'h77;
    exm_valid = 1; exm_reg_write = 1; exm_rd = 31; exm_result = 64'hA0;
    cyc("zero_reg", 0, M_V | M_A, 1, 0, 0, 0, 0, 0, 0);

    // Forwarding priority on rm
    id_rn = 0; ReadData1 = 0; id_rm = 5; ReadData2 = 64'h333;
    exm_valid = 1; exm_reg_write = 1; exm_rd = 5; exm_result = 64'h111;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5; wb_data = 64'h222;
    cyc("fwd_exm", 0, M_B | M_SD, 1, 0, 64'h111, 64'h111, 0, 0, 0);
    exm_valid = 0;
    cyc("fwd_wb", 0, M_B | M_SD, 1, 0, 64'h222, 64'h222, 0, 0, 0);
    wb_valid = 0;
    cyc("fwd_rf", 0, M_B | M_SD, 1, 0, 64'h333, 64'h333, 0, 0, 0);
    clear_fwd();

    // Load X7, then a consumer of X7
    id_rn = 1; ReadData1 = 64'h1000; id_rm = 2; id_use_imm = 1; id_imm = 64'h8;
    id_rd = 7; id_mem_read = 1; id_reg_write = 1;
    cyc("ldur_x7", 0, M_V | M_A | M_B | M_RD | M_MR, 1, 64'h1000, 64'h8, 0, 7, 1, 1);
    id_rn = 7; id_rm = 4; id_use_imm = 0; id_mem_read = 0; id_rd = 9; ReadData1 = 0;
    cyc("lu_bubble", 1, M_V | M_RW | M_MR, 0, 0, 0, 0, 0, 0, 0);
    exm_valid = 1; exm_reg_write = 1; exm_rd = 7; exm_result = 64'hBEEF;
    cyc("lu_resolve", 0, M_V | M_A | M_RD | M_RW | M_MR, 1, 64'hBEEF, 0, 0, 9, 1, 0);
    clear_fwd();

    // Immediate operand vs store data, issued as a load
    id_rn = 1; ReadData1 = 64'h1; id_rm = 2; ReadData2 = 64'h55;
    id_use_imm = 1; id_imm = 64'h10; id_mem_read = 1; id_rd = 6;
    cyc("imm_store", 0, M_V | M_B | M_SD | M_RD | M_MR, 1, 0, 64'h10, 64'h55, 6, 1, 1);

    // Flush together with a load-use hazard
    id_rn = 6; id_mem_read = 0; id_rd = 3; flush = 1;
    cyc("flush_lu", 0, M_V | M_RW | M_MR, 0, 0, 0, 0, 0, 0, 0);
    flush = 0;

    // Back-to-back dependent loads
    id_rn = 1; id_rm = 2; id_use_imm = 1; id_imm = 64'h20; id_mem_read = 1; id_rd = 8;
    cyc("ld_x8", 0, M_V | M_RD | M_MR, 1, 0, 0, 0, 8, 1, 1);
    id_rn = 8; id_rd = 9;
    cyc("ld_x9_stall", 1, M_V | M_MR, 0, 0, 0, 0, 0, 0, 0);
    exm_valid = 1; exm_reg_write = 1; exm_rd = 8; exm_result = 64'h800;
    cyc("ld_x9_go", 0, M_V | M_A | M_RD | M_MR, 1, 64'h800, 0, 0, 9, 1, 1);
    clear_fwd();
    // rm hazard is detected even with use_imm set
    id_rn = 1; ReadData1 = 64'h1; id_rm = 9; id_imm = 64'h30; id_mem_read = 0; id_rd = 10;
    cyc("rm_imm_stall", 1, M_V, 0, 0, 0, 0, 0, 0, 0);
    exm_valid = 1; exm_reg_write = 1; exm_rd = 9; exm_result = 64'h900;
    cyc("rm_imm_go", 0, M_ALL, 1, 64'h1, 64'h30, 64'h900, 10, 1, 0);
    clear_fwd();

    // Hold freezes ID/EX, release captures the pending slot
    id_rn = 2; ReadData1 = 64'h2222; ReadData2 = 64'h99; id_rd = 11; hold = 1;
    cyc("hold", 1, M_ALL, 1, 64'h1, 64'h30, 64'h900, 10, 1, 0);
    hold = 0;
    cyc("release", 0, M_V | M_A | M_SD | M_RD, 1, 64'h2222, 0, 64'h99, 11, 0, 0);

    // Reset arriving while a load-use stall is pending
    id_rn = 0; id_mem_read = 1; id_rd = 12;
    cyc("ld_x12", 0, M_V | M_RD | M_MR, 1, 0, 0, 0, 12, 1, 1);
    id_rn = 12; id_mem_read = 0; id_rd = 13; reset = 1;
    cyc("reset_stall", 0, M_ALL, 0, 0, 0, 0, 0, 0, 0);
    reset = 0; id_valid = 0; id_reg_write = 1; id_mem_read = 1;
    cyc("idle_gated", 0, M_V | M_RW | M_MR, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    checks++;
    if (cq.size() != 0 || eq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", cq.size() + eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_fetch_stage
`default_nettype wire
